seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//  Sequential unsigned restoring divider: divides a 2N-bit dividend by an N-bit divisor, giving an
//  N-bit quotient and N-bit remainder. Inverse of the NxN array multiplier on the MAC datapath.
//  Used for normalisation and result checks. One restoring step per clock.
//  Valid/ready handshake on input and output.
// PARAMETERS
//  N   4   divisor/quotient/remainder width; dividend width is 2N
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous active-low reset
//  in_valid   in   1   dividend/divisor valid
//  in_ready   out  1   block can accept an operand pair
//  dividend   in   2N  unsigned dividend
//  divisor    in   N   unsigned divisor
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  quotient   out  N   unsigned quotient
//  remainder  out  N   unsigned remainder
//  div_zero   out  1   divisor was 0
//  ovf        out  1   quotient does not fit in N bits
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-low (rst_n), sampled on rising edge; overrides all.
//  - Reset: state=IDLE, in_ready=1, out_valid=0; quotient, remainder, div_zero and ovf are 0.
//  - FSM states are IDLE, CALC, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
//  - Accept: the operand pair is taken on the edge with in_valid && in_ready.
//  - On accept, a divisor of 0 has priority:
//    - Go to DONE next edge.
//    - div_zero=1, ovf=0, quotient={N{1}}, remainder=dividend[N-1:0].
//  - On accept, if dividend[2N-1:N] >= divisor (divisor nonzero):
//    - Go to DONE next edge.
//    - ovf=1, div_zero=0, quotient={N{1}}, remainder=dividend[N-1:0].
//  - Otherwise, on accept:
//    - R(N+1b) = {1'b0, dividend[2N-1:N]}, Q = dividend[N-1:0], step counter = N-1, go to CALC.
//  - Each CALC edge does one restoring step:
//    - {R,Q} shifted left by 1; T = R - {1'b0,divisor}.
//    - If T >= 0: R=T and Q[0]=1; else R is kept and Q[0]=0.
//    - At counter 0, go to DONE; otherwise decrement.
//  - Latency:
//    - Normal case: out_valid rises N edges after the accept edge.
//    - Error cases: out_valid rises 1 edge after the accept edge.
//  - DONE: outputs are held stable while out_valid && !out_ready (backpressure, no loss).
//    - On out_valid && out_ready, go to IDLE; in_ready=1 on the next cycle.
//    - A new input is not accepted in that same edge.
//  - Results are registered outputs and hold their last value in IDLE and CALC. Flags clear on each new accept.
//  - in_valid while busy is ignored; the source holds its data (standard handshake).
//  - Reset mid-CALC/DONE aborts: the in-flight result is discarded and reset values are restored.
//  - Invariant: dividend == quotient*divisor + remainder and remainder < divisor, whenever !div_zero && !ovf.
// STRUCTURE
//  - Shared package (mac_pkg): state enum (IDLE/CALC/DONE), default N, counter width $clog2(N).
//  - Sub-module div_step:
//    - Purely combinational restoring step.
//    - Inputs: R, Q, divisor. Outputs: R_next, Q_next.
//    - Instantiated once; the FSM and registers sit in the top level.
// TESTING (N=4)
//  1. dividend=200 (0xC8), divisor=13 -> after 4 edges: quotient=15, remainder=5, flags 0.
//  2. dividend=0x78, divisor=15 -> quotient=8, remainder=0; dividend=0, divisor=7 -> 0 r 0.
//  3. dividend=0xF0, divisor=3 -> 1 edge later: ovf=1, quotient=0xF, remainder=0x0.
//     dividend=0x30, divisor=3 (high nibble == divisor) -> ovf=1.
//  4. dividend=0x2A, divisor=0 -> div_zero=1, quotient=0xF, remainder=0xA, out_valid after 1 edge.
//  5. Hold out_ready=0 for 5 cycles in DONE -> out_valid and data stable, in_ready=0.
//     Release -> IDLE next edge, back-to-back ops correct.
//  6. Assert rst_n=0 during CALC step 2 -> next edge IDLE, in_ready=1, out_valid=0, outputs 0.
//     Then 100/7 -> 14 r 2.
//  Plus random: all 2^12 operand pairs checked against the invariant / flag rules.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC-datapath helper blocks.
//   state_t     : sequencing states of the restoring divider
//   N_DEFAULT   : default divisor/quotient/remainder width
//   cnt_width() : width of the step counter for a given N (at least 1 bit)
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step.
//   r       : partial remainder (N+1 bits)
//   q       : dividend/quotient shift register (N bits)
//   divisor : unsigned divisor (N bits)
//   r_next  : partial remainder after the step
//   q_next  : shift register after the step, new quotient bit in bit 0
module div_step
    import mac_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N+1:0] diff;
    logic [N:0]   r_keep;
    logic [N:0]   q_ext;
    logic         neg;

    // r < divisor holds on entry, so the shifted remainder fits in N+1 bits
    // and the top bit of the N+2-bit difference is a clean borrow flag.
    assign diff   = {r, q[N-1]} - {2'b00, divisor};
    assign neg    = diff[N+1];
    assign r_keep = {r[N-1:0], q[N-1]};
    assign r_next = neg ? r_keep : diff[N:0];
    assign q_ext  = {q, ~neg};
    assign q_next = q_ext[N-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one restoring step per clock, valid/ready handshake on both sides.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid, in_ready    : operand handshake
//   dividend, divisor     : operands (2N and N bits)
//   out_valid, out_ready  : result handshake
//   quotient, remainder   : registered result (N bits each)
//   div_zero, ovf         : divisor was zero / quotient would not fit in N bits
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// CALC  | one restoring step per edge; error cases spend one idle edge here
// DONE  | result presented, held until out_ready
module seq_restoring_divider
    import mac_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    localparam int CW = cnt_width(N);

    state_t         state;
    state_t         state_nx;
    logic [N:0]     r_q;
    logic [N-1:0]   q_q;
    logic [N-1:0]   dvs_q;
    logic [CW-1:0]  cnt;
    logic           err_dz;
    logic           err_ovf;
    logic [N:0]     r_step;
    logic [N-1:0]   q_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_step #(.N(N)) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (dvs_q),
        .r_next  (r_step),
        .q_next  (q_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = CALC;
            CALC: if (cnt == '0) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            cnt       <= '0;
            err_dz    <= 1'b0;
            err_ovf   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs_q    <= divisor;
                        q_q      <= dividend[N-1:0];
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                        if (divisor == '0) begin
                            err_dz  <= 1'b1;
                            err_ovf <= 1'b0;
                            r_q     <= '0;
                            cnt     <= '0;
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            err_dz  <= 1'b0;
                            err_ovf <= 1'b1;
                            r_q     <= '0;
                            cnt     <= '0;
                        end else begin
                            err_dz  <= 1'b0;
                            err_ovf <= 1'b0;
                            r_q     <= {1'b0, dividend[2*N-1:N]};
                            cnt     <= CW'(N - 1);
                        end
                    end
                end
                CALC: begin
                    if (err_dz || err_ovf) begin
                        // Error path: counter is already 0, publish saturated result.
                        quotient  <= '1;
                        remainder <= q_q;
                        div_zero  <= err_dz;
                        ovf       <= err_ovf;
                    end else begin
                        r_q <= r_step;
                        q_q <= q_step;
                        if (cnt == '0) begin
                            quotient  <= q_step;
                            remainder <= r_step[N-1:0];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
